irl_refill_sched: RTL
=====================

Name: irl_refill_sched

Overview:
- Sweeps all flow entries of the ingress rate limiter memories on every refill tick and adds CIR/EIR tokens to each flow's token bucket, clamped to the configured burst size.
- Owns the scheduler-side read/write ports of the fill-source, limiting-profile and token-bucket RAMs.
- Snoops datapath token-bucket writes so a refill never overwrites a fresher datapath update.

Parameters:
DEPTH_NBITS, 10, flow index width; sweep covers 0..2^DEPTH_NBITS-1
LIMITER_NBITS, 8, limiting-profile index width
CIR_NBITS, 16, CIR rate/burst field width; CIR bucket is CIR_NBITS+2
EIR_NBITS, 16, EIR rate/burst field width; EIR bucket is EIR_NBITS+2
FILL_TB_NBITS, LIMITER_NBITS+1, fill-source entry: [MSB]=enable, [LIMITER_NBITS-1:0]=limiter id
PROFILE_NBITS, 32, profile entry: [15:0]=rate, [31:16]=burst

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
refill_en  in  1  register enable for sweeping
refill_tick  in  1  single-cycle pulse that starts one sweep
fill_tb_src_rd  out  1  fill-source read strobe
fill_tb_src_raddr  out  DEPTH_NBITS  fill-source read address
fill_tb_src_ack  in  1  fill-source read ack, 1 cycle after rd
fill_tb_src_rdata  in  FILL_TB_NBITS  fill-source read data
limiting_profile_cir_rd / _eir_rd  out  1  profile read strobes, issued together
limiting_profile_cir_raddr / _eir_raddr  out  LIMITER_NBITS  profile read addresses = limiter id
limiting_profile_cir_ack / _eir_ack  in  1  profile read acks, variable latency
limiting_profile_cir_rdata / _eir_rdata  in  PROFILE_NBITS  profile read data
token_bucket_rd  out  1  bucket read strobe
token_bucket_raddr  out  DEPTH_NBITS  bucket read address
token_bucket_ack  in  1  bucket read ack, 1 cycle
token_bucket_rdata  in  CIR_NBITS+EIR_NBITS+4  bucket read data, {eir_tb, cir_tb}
token_bucket_wr  out  1  bucket write strobe
token_bucket_waddr  out  DEPTH_NBITS  bucket write address
token_bucket_wdata  out  CIR_NBITS+EIR_NBITS+4  bucket write data, {eir_tb, cir_tb}
dp_tb_wr  in  1  datapath bucket write, snooped
dp_tb_waddr  in  DEPTH_NBITS  datapath bucket write address
sweep_busy  out  1  sweep in progress
sweep_done  out  1  one-cycle pulse at end of a sweep
overrun_cnt  out  16  saturating count of ticks arriving while busy

Behaviour:
- Reset: FSM goes to IDLE. All strobes, sweep_busy, sweep_done, overrun_cnt and the flow pointer reset to 0. Address and data outputs reset to 0.
- FSM states and transitions:
  - IDLE: on refill_tick & refill_en, pointer=0 and go to RD_SRC.
  - RD_SRC: pulse fill_tb_src_rd, then go to W_SRC.
  - W_SRC: wait for ack. If enable bit=0, go to NEXT (no write). Otherwise latch limiter id and go to RD_PROF.
  - RD_PROF: pulse both profile rd strobes, then go to W_PROF.
  - W_PROF: acks may arrive in any order and any cycle; capture each independently. When both are held, go to RD_TB.
  - RD_TB: pulse token_bucket_rd, clear the hazard flag, then go to W_TB.
  - W_TB: on ack, latch the bucket and go to CALC.
  - CALC: new_cir = min(cir_tb + rate_cir, {2'b0,burst_cir}), computed at CIR_NBITS+3 bits before clamping; EIR likewise. If the bucket already exceeds burst, the result is burst (clamp down). Go to WR.
  - WR: if the hazard flag is set, go back to RD_TB (retry the flow). Otherwise pulse token_bucket_wr with waddr=pointer and go to NEXT.
  - NEXT: if pointer = all-ones, pulse sweep_done and go to IDLE. Else if refill_en=0, go to IDLE without sweep_done. Else increment pointer and go to RD_SRC.
- Hazard: hazard flag sets on any dp_tb_wr with dp_tb_waddr == pointer from RD_TB through WR inclusive. A dp write in the same cycle as WR cancels that write and forces a retry.
- sweep_busy = 1 in every state except IDLE.
- refill_tick while busy: overrun_cnt += 1, saturating at 0xFFFF. The tick is dropped, not queued.
- refill_tick in IDLE with refill_en=0: ignored, not counted.
- At most one strobe asserted per cycle per RAM. The write strobe is never asserted in the same cycle as a bucket read strobe.
- Reset asserted mid-sweep: abort immediately, no partial write.

Decomposition:
- Shared package/defines: profile field offsets (rate/burst), fill-source enable bit position, bucket field packing, FSM state encodings.
- One natural sub-module: irl_tb_sat_add (parameterised width; add rate to bucket, clamp to burst). Instantiated twice, for CIR and EIR.

Test Plan:
- DEPTH_NBITS=2, all flows enabled, cir_tb=10, rate=5, burst=100, one tick -> 4 writes with cir=15; sweep_done 1 cycle after the 4th write.
- cir_tb=98, rate=5, burst=100 -> written cir=100. cir_tb=0x3FFFF, burst=50 -> written cir=50 (no wrap).
- Flow 1 enable=0 -> no token_bucket_wr to address 1; flows 0, 2, 3 written.
- dp_tb_wr to the current flow in W_TB -> bucket re-read once; a single write carrying refreshed data+rate.
- Second tick mid-sweep, then 70000 more ticks -> overrun_cnt 1, then saturates at 0xFFFF; sweep completes unaffected.
- EIR ack 3 cycles after CIR ack; then rst_n low during W_TB -> correct write for the late-ack flow; after reset all outputs 0, FSM in IDLE, no write issued.

Source files
------------

// File: rtl/irl_refill_sched_pkg.sv
// Shared definitions for the ingress rate limiter refill scheduler.
// Holds profile field layout, bucket packing helpers and FSM state codes.
package irl_refill_sched_pkg;

    // Profile entry layout: [15:0]=rate, [31:16]=burst
    localparam int PROF_RATE_LSB  = 0;
    localparam int PROF_BURST_LSB = 16;

    // Refill FSM state encodings
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_RD_SRC  = 4'd1;
    localparam logic [3:0] ST_W_SRC   = 4'd2;
    localparam logic [3:0] ST_RD_PROF = 4'd3;
    localparam logic [3:0] ST_W_PROF  = 4'd4;
    localparam logic [3:0] ST_RD_TB   = 4'd5;
    localparam logic [3:0] ST_W_TB    = 4'd6;
    localparam logic [3:0] ST_CALC    = 4'd7;
    localparam logic [3:0] ST_WR      = 4'd8;
    localparam logic [3:0] ST_NEXT    = 4'd9;

    // Fill-source enable bit sits directly above the limiter id
    function automatic int fill_en_bit(input int lim_nbits);
        return lim_nbits;
    endfunction

    // Bucket word is {eir_tb, cir_tb}; cir bucket starts at bit 0
    function automatic int eir_tb_lsb(input int cir_nbits);
        return cir_nbits + 2;
    endfunction

endpackage

// File: rtl/irl_refill_sched_sat_add.sv
// Token bucket refill adder: bucket + rate, clamped to burst.
// Ports: bucket_i (N+2), rate_i (N), burst_i (N) -> result_o (N+2).
module irl_tb_sat_add #(
    parameter int N = 16
) (
    input  logic [N+1:0] bucket_i,
    input  logic [N-1:0] rate_i,
    input  logic [N-1:0] burst_i,
    output logic [N+1:0] result_o
);

    // One extra bit so an all-ones bucket plus rate cannot wrap.
    logic [N+2:0] sum;
    logic [N+2:0] lim;

    assign sum = {1'b0, bucket_i} + {3'b000, rate_i};
    assign lim = {3'b000, burst_i};

    // Also clamps down a bucket that already exceeds burst.
    assign result_o = (sum > lim) ? {2'b00, burst_i} : sum[N+1:0];

endmodule

// File: rtl/irl_refill_sched.sv
// Refill sweep scheduler: walks every flow on each refill tick and tops up
// its CIR/EIR token buckets from the flow's limiting profile, clamped to
// burst. Ports: refill control (refill_en/tick), fill-source, profile and
// token-bucket RAM ports, datapath write snoop, sweep status/overrun count.
module irl_refill_sched
    import irl_refill_sched_pkg::*;
#(
    parameter int DEPTH_NBITS   = 10,
    parameter int LIMITER_NBITS = 8,
    parameter int CIR_NBITS     = 16,
    parameter int EIR_NBITS     = 16,
    parameter int FILL_TB_NBITS = LIMITER_NBITS + 1,
    parameter int PROFILE_NBITS = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               refill_en,
    input  logic                               refill_tick,
    output logic                               fill_tb_src_rd,
    output logic [DEPTH_NBITS-1:0]             fill_tb_src_raddr,
    input  logic                               fill_tb_src_ack,
    input  logic [FILL_TB_NBITS-1:0]           fill_tb_src_rdata,
    output logic                               limiting_profile_cir_rd,
    output logic [LIMITER_NBITS-1:0]           limiting_profile_cir_raddr,
    input  logic                               limiting_profile_cir_ack,
    input  logic [PROFILE_NBITS-1:0]           limiting_profile_cir_rdata,
    output logic                               limiting_profile_eir_rd,
    output logic [LIMITER_NBITS-1:0]           limiting_profile_eir_raddr,
    input  logic                               limiting_profile_eir_ack,
    input  logic [PROFILE_NBITS-1:0]           limiting_profile_eir_rdata,
    output logic                               token_bucket_rd,
    output logic [DEPTH_NBITS-1:0]             token_bucket_raddr,
    input  logic                               token_bucket_ack,
    input  logic [CIR_NBITS+EIR_NBITS+3:0]     token_bucket_rdata,
    output logic                               token_bucket_wr,
    output logic [DEPTH_NBITS-1:0]             token_bucket_waddr,
    output logic [CIR_NBITS+EIR_NBITS+3:0]     token_bucket_wdata,
    input  logic                               dp_tb_wr,
    input  logic [DEPTH_NBITS-1:0]             dp_tb_waddr,
    output logic                               sweep_busy,
    output logic                               sweep_done,
    output logic [15:0]                        overrun_cnt
);

    localparam int CB     = CIR_NBITS + 2;
    localparam int EB     = EIR_NBITS + 2;
    localparam int TBW    = CB + EB;
    localparam int EN_BIT = fill_en_bit(LIMITER_NBITS);
    localparam int E_LSB  = eir_tb_lsb(CIR_NBITS);

    logic [3:0]               state_q, state_d;
    logic [DEPTH_NBITS-1:0]   ptr_q, ptr_d;
    logic [LIMITER_NBITS-1:0] lim_q, lim_d;
    logic                     cir_got_q, cir_got_d;
    logic                     eir_got_q, eir_got_d;
    logic [PROFILE_NBITS-1:0] cir_prof_q, cir_prof_d;
    logic [PROFILE_NBITS-1:0] eir_prof_q, eir_prof_d;
    logic [CB-1:0]            cir_tb_q, cir_tb_d;
    logic [EB-1:0]            eir_tb_q, eir_tb_d;
    logic [TBW-1:0]           wdata_q, wdata_d;
    logic                     hazard_q, hazard_d;
    logic [15:0]              ovr_q, ovr_d;

    logic                     dp_hit;
    logic                     busy;
    logic [CB-1:0]            cir_new;
    logic [EB-1:0]            eir_new;

    assign dp_hit = dp_tb_wr && (dp_tb_waddr == ptr_q);
    assign busy   = (state_q != ST_IDLE);

    irl_tb_sat_add #(.N(CIR_NBITS)) u_cir_add (
        .bucket_i (cir_tb_q),
        .rate_i   (cir_prof_q[PROF_RATE_LSB +: CIR_NBITS]),
        .burst_i  (cir_prof_q[PROF_BURST_LSB +: CIR_NBITS]),
        .result_o (cir_new)
    );

    irl_tb_sat_add #(.N(EIR_NBITS)) u_eir_add (
        .bucket_i (eir_tb_q),
        .rate_i   (eir_prof_q[PROF_RATE_LSB +: EIR_NBITS]),
        .burst_i  (eir_prof_q[PROF_BURST_LSB +: EIR_NBITS]),
        .result_o (eir_new)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lim_d      = lim_q;
        cir_got_d  = cir_got_q;
        eir_got_d  = eir_got_q;
        cir_prof_d = cir_prof_q;
        eir_prof_d = eir_prof_q;
        cir_tb_d   = cir_tb_q;
        eir_tb_d   = eir_tb_q;
        wdata_d    = wdata_q;
        hazard_d   = hazard_q;
        ovr_d      = ovr_q;

        // Ticks during a sweep are dropped but counted.
        if (refill_tick && busy && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (refill_tick && refill_en) begin
                    ptr_d   = '0;
                    state_d = ST_RD_SRC;
                end
            end
            ST_RD_SRC: state_d = ST_W_SRC;
            ST_W_SRC: begin
                if (fill_tb_src_ack) begin
                    if (fill_tb_src_rdata[EN_BIT]) begin
                        lim_d   = fill_tb_src_rdata[LIMITER_NBITS-1:0];
                        state_d = ST_RD_PROF;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_RD_PROF: begin
                cir_got_d = 1'b0;
                eir_got_d = 1'b0;
                state_d   = ST_W_PROF;
            end
            ST_W_PROF: begin
                if (limiting_profile_cir_ack && !cir_got_q) begin
                    cir_prof_d = limiting_profile_cir_rdata;
                    cir_got_d  = 1'b1;
                end
                if (limiting_profile_eir_ack && !eir_got_q) begin
                    eir_prof_d = limiting_profile_eir_rdata;
                    eir_got_d  = 1'b1;
                end
                if (cir_got_d && eir_got_d) begin
                    state_d = ST_RD_TB;
                end
            end
            ST_RD_TB: begin
                // Fresh read: only a write landing now can taint it.
                hazard_d = dp_hit;
                state_d  = ST_W_TB;
            end
            ST_W_TB: begin
                hazard_d = hazard_q | dp_hit;
                if (token_bucket_ack) begin
                    cir_tb_d = token_bucket_rdata[CB-1:0];
                    eir_tb_d = token_bucket_rdata[E_LSB +: EB];
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                hazard_d = hazard_q | dp_hit;
                wdata_d  = {eir_new, cir_new};
                state_d  = ST_WR;
            end
            ST_WR: begin
                // Datapath beat us to this bucket: re-read and recompute.
                if (hazard_q || dp_hit) begin
                    state_d = ST_RD_TB;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (&ptr_q) begin
                    state_d = ST_IDLE;
                end else if (!refill_en) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ST_RD_SRC;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            lim_q      <= '0;
            cir_got_q  <= 1'b0;
            eir_got_q  <= 1'b0;
            cir_prof_q <= '0;
            eir_prof_q <= '0;
            cir_tb_q   <= '0;
            eir_tb_q   <= '0;
            wdata_q    <= '0;
            hazard_q   <= 1'b0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lim_q      <= lim_d;
            cir_got_q  <= cir_got_d;
            eir_got_q  <= eir_got_d;
            cir_prof_q <= cir_prof_d;
            eir_prof_q <= eir_prof_d;
            cir_tb_q   <= cir_tb_d;
            eir_tb_q   <= eir_tb_d;
            wdata_q    <= wdata_d;
            hazard_q   <= hazard_d;
            ovr_q      <= ovr_d;
        end
    end

    // Strobes decode straight from state, so each RAM sees one per cycle
    // and bucket rd/wr live in different states.
    assign fill_tb_src_rd             = (state_q == ST_RD_SRC);
    assign fill_tb_src_raddr          = ptr_q;
    assign limiting_profile_cir_rd    = (state_q == ST_RD_PROF);
    assign limiting_profile_eir_rd    = (state_q == ST_RD_PROF);
    assign limiting_profile_cir_raddr = lim_q;
    assign limiting_profile_eir_raddr = lim_q;
    assign token_bucket_rd            = (state_q == ST_RD_TB);
    assign token_bucket_raddr         = ptr_q;
    assign token_bucket_wr            = (state_q == ST_WR) && !hazard_q && !dp_hit;
    assign token_bucket_waddr         = ptr_q;
    assign token_bucket_wdata         = wdata_q;
    assign sweep_busy                 = busy;
    assign sweep_done                 = (state_q == ST_NEXT) && (&ptr_q);
    assign overrun_cnt                = ovr_q;

endmodule
